// File: rtl/amba_apb_pkg.sv
// Shared APB definitions: slave FSM states, default bus widths and the bus-phase
// encoding also used by the matching APB master.
package amba_apb_pkg;

    localparam int unsigned ApbAddrW = 8;
    localparam int unsigned ApbDataW = 8;
    localparam int unsigned ApbCntW  = 4;

    localparam logic [1:0] ApbPhaseIdle   = 2'b00;
    localparam logic [1:0] ApbPhaseSetup  = 2'b01;
    localparam logic [1:0] ApbPhaseAccess = 2'b10;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } apb_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W register file: async clear, one synchronous write port and one
// combinational read port that returns zero for out-of-range addresses.
module apb_slave_regfile
    import amba_apb_pkg::*;
#(
    parameter int unsigned ADDR_W = ApbAddrW,
    parameter int unsigned DATA_W = ApbDataW,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (addr_in_range(32'(raddr_i), DEPTH)) begin
            rdata_o = mem_q[raddr_i[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/amba_apb_slave.sv
// APB completer with a byte-wide register file, programmable wait states and
// pslverr for addresses beyond DEPTH. All outputs are registered.
module amba_apb_slave
    import amba_apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ApbAddrW,
    parameter int unsigned DATA_W      = ApbDataW,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ApbCntW-1:0] WaitLoad = ApbCntW'(WAIT_CYCLES);
    localparam logic NoWait = (WAIT_CYCLES == 0);

    apb_state_e state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [ApbCntW-1:0] cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;

    logic              setup, access;
    logic              respond, clear, mem_we;
    logic              rsp_write, rsp_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign setup  = psel_i & ~penable_i;
    assign access = psel_i & penable_i;

    // A setup cycle responds from the live bus; later wait cycles use the latched copy.
    assign rd_addr   = setup ? paddr_i : addr_q;
    assign rsp_write = setup ? pwrite_i : write_q;
    assign rsp_err   = ~addr_in_range(32'(rd_addr), DEPTH);

    apb_slave_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IdxW)
    ) u_regfile (
        .clk_i   (pclk_i),
        .rst_i   (preset_i),
        .we_i    (mem_we),
        .waddr_i (addr_q[IdxW-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (setup) state_d = StWait;
            StWait: begin
                if (!psel_i) begin
                    state_d = StIdle;
                end else if (access && pready_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        respond   = 1'b0;
        clear     = 1'b0;
        mem_we    = 1'b0;

        // Setup is honoured in either state; in WAIT it abandons the old transfer.
        if (setup) begin
            addr_d  = paddr_i;
            write_d = pwrite_i;
            wdata_d = pwdata_i;
            cnt_d   = WaitLoad;
        end

        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    clear   = 1'b1;
                    respond = NoWait;
                end
            end
            StWait: begin
                if (!psel_i) begin
                    clear = 1'b1;
                end else if (setup) begin
                    clear   = 1'b1;
                    respond = NoWait;
                end else if (!pready_q) begin
                    if (cnt_q > ApbCntW'(1)) begin
                        cnt_d = cnt_q - ApbCntW'(1);
                    end else begin
                        cnt_d   = '0;
                        respond = 1'b1;
                    end
                end else begin
                    mem_we = write_q & ~pslverr_q;
                    clear  = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase

        if (clear) begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
        end
        if (respond) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = (!rsp_write && !rsp_err) ? rd_data : '0;
        end
    end

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;

endmodule

// File: doc/amba_apb_slave.md
Name: amba_apb_slave

Overview:
APB completer (slave) that terminates transfers issued by the team's APB master.
- Holds an internal byte-wide register file, written and read over APB.
- Inserts a parameterised number of wait states by holding pready low.
- Flags out-of-range addresses with pslverr.
- Sits on the peripheral side of the APB bus, one instance per psel line.

Parameters:
- ADDR_W, 8, width of paddr.
- DATA_W, 8, width of pwdata and prdata.
- DEPTH, 64, number of register-file words; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15).

Ports:
- pclk  in  1  bus clock; all state changes on the rising edge.
- preset  in  1  reset, asynchronous, active-high.
- psel  in  1  slave select from the master.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  transfer address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data; valid while pready=1 on a read.
- pready  out  1  transfer completes on the edge where psel & penable & pready are all 1.
- pslverr  out  1  error response, qualified by pready.

Behaviour:
- Reset (async, preset=1):
  - state=IDLE; pready=0, pslverr=0, prdata=0; wait counter=0.
  - All DEPTH register-file words cleared to 0.
  - Reset asserted mid-transfer aborts the transfer; no write is committed.
- FSM states and transitions:
  - IDLE -> WAIT: on an edge with psel=1 & penable=0 (setup phase).
    - Latch paddr, pwrite and pwdata into internal registers.
    - Load wait counter = WAIT_CYCLES.
    - pready <= (WAIT_CYCLES==0).
    - If pready will be 1: pslverr <= (paddr >= DEPTH), and prdata <= (read & in range) ? mem[paddr] : 0.
  - WAIT, edge with psel=1 & penable=1 & pready=0:
    - Counter decrements.
    - When the counter reaches 0, assert pready, pslverr and prdata as above, using the latched address.
  - WAIT, edge with psel=1 & penable=1 & pready=1 (completion):
    - Write & no error: mem[latched addr] <= latched pwdata.
    - pready <= 0, pslverr <= 0, prdata <= 0; go to IDLE.
  - WAIT, edge with psel=0 (master abandoned the transfer): go to IDLE, clear pready/pslverr/prdata, no write.
- Latency:
  - WAIT_CYCLES=0: zero-wait transfer, two bus cycles (setup + access).
  - Otherwise: 2 + WAIT_CYCLES cycles.
- Back-to-back: the completion edge returns to IDLE, so the master's next SETUP cycle is accepted immediately with no idle cycle required.
- Address/data hold: address and data are sampled only at setup. Changes to paddr/pwdata during the access phase are ignored.
- Protocol violations:
  - penable=1 seen in IDLE without a prior setup: ignored, pready stays 0.
  - psel=1 & penable=0 seen in WAIT: treated as abort plus a new setup (relatch, reload counter).
- Error transfers:
  - Address >= DEPTH completes normally with pslverr=1.
  - Writes are discarded and prdata=0.
- Output timing: all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package amba_apb_pkg:
  - State enum {IDLE, WAIT}.
  - Default ADDR_W/DATA_W constants.
  - Bus-phase encoding constants shared with the master (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10).
- One sub-module, apb_slave_regfile:
  - DEPTH x DATA_W storage with async clear, one synchronous write port and one combinational read port.
  - The FSM, wait counter and response logic stay in amba_apb_slave.

Test Plan:
- Reset: assert preset asynchronously mid-cycle -> pready=0, pslverr=0, prdata=0 immediately; a read of addr 0x05 afterwards returns 0x00.
- WAIT_CYCLES=0: write 0xA5 to 0x10, then read 0x10 -> each transfer takes 2 cycles, pready=1 in the access cycle, read returns prdata=0xA5, pslverr=0.
- WAIT_CYCLES=3: write 0x3C to 0x01 -> pready low for 3 access cycles and high on the 4th; mem[0x01]=0x3C only after the completion edge.
- Error: DEPTH=64, write 0x77 to 0x40, then read 0x40 -> pslverr=1 with pready=1 on both transfers; read prdata=0x00; mem[0x00] is unchanged.
- Back-to-back with the master's transfer held high: write 0x11 to 0x02, then immediately read 0x02 -> no idle cycle between transfers, prdata=0x11.
- Abort: WAIT_CYCLES=2, drop psel during the second wait cycle of a write of 0xFF to 0x03 -> slave returns to IDLE; a later read of 0x03 returns the old value 0x00.
